// File: rtl/hmc_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// hmc_mem_responder_pkg
//   Shared constants for the HMC memory responder and its interface:
//   command encodings used on the Pico HMC user interface, bus widths,
//   and the byte-write lane merge helper.
// ---------------------------------------------------------------------------
package hmc_mem_responder_pkg;

  // Command encodings shared with the requester (bridge) side.
  localparam logic [3:0] HMC_CMD_WR = 4'b0001;
  localparam logic [3:0] HMC_CMD_RD = 4'b0010;
  localparam logic [3:0] HMC_CMD_BW = 4'b0011;

  localparam int HMC_ADDR_W    = 34;
  localparam int HMC_DATA_W    = 128;
  localparam int HMC_ERRSTAT_W = 7;

  // Byte-write merge: a mask bit of 1 keeps the old bit, 0 takes the new one.
  function automatic logic [63:0] bw_merge(input logic [63:0] old_word,
                                           input logic [63:0] new_data,
                                           input logic [63:0] mask);
    return (old_word & mask) | (new_data & ~mask);
  endfunction

endpackage

// File: rtl/hmc_mem_responder_if.sv
// ---------------------------------------------------------------------------
// hmc_mem_responder_if
//   Pico HMC user-interface bundle: command channel, write-flit channel,
//   read-flit channel and status.
//   modport master : requester side (drives commands / write flits)
//   modport slave  : responder side (hmc_mem_responder)
// ---------------------------------------------------------------------------
interface hmc_mem_responder_if #(
  parameter int TAG_WIDTH = 6
);
  import hmc_mem_responder_pkg::*;

  // command channel
  logic                     hmc_cmd_valid;
  logic                     hmc_cmd_ready;
  logic [3:0]               hmc_cmd;
  logic [HMC_ADDR_W-1:0]    hmc_addr;
  logic [3:0]               hmc_size;
  logic [TAG_WIDTH-1:0]     hmc_tag;
  // write-flit channel
  logic [HMC_DATA_W-1:0]    hmc_wr_data;
  logic                     hmc_wr_data_valid;
  logic                     hmc_wr_data_ready;
  // read-flit channel
  logic [HMC_DATA_W-1:0]    hmc_rd_data;
  logic [TAG_WIDTH-1:0]     hmc_rd_data_tag;
  logic                     hmc_rd_data_valid;
  logic                     hmc_rd_data_ready;
  // status
  logic [HMC_ERRSTAT_W-1:0] hmc_errstat;
  logic                     hmc_dinv;

  modport master (
    output hmc_cmd_valid, hmc_cmd, hmc_addr, hmc_size, hmc_tag,
    output hmc_wr_data, hmc_wr_data_valid, hmc_rd_data_ready,
    input  hmc_cmd_ready, hmc_wr_data_ready,
    input  hmc_rd_data, hmc_rd_data_tag, hmc_rd_data_valid,
    input  hmc_errstat, hmc_dinv
  );

  modport slave (
    input  hmc_cmd_valid, hmc_cmd, hmc_addr, hmc_size, hmc_tag,
    input  hmc_wr_data, hmc_wr_data_valid, hmc_rd_data_ready,
    output hmc_cmd_ready, hmc_wr_data_ready,
    output hmc_rd_data, hmc_rd_data_tag, hmc_rd_data_valid,
    output hmc_errstat, hmc_dinv
  );

endinterface

// File: rtl/hmc_resp_ram.sv
// ---------------------------------------------------------------------------
// hmc_resp_ram
//   Simple dual-port RAM, one write port and one read port, 2**LOG_DEPTH
//   words of WIDTH bits. Registered read; a same-address read and write in
//   one cycle return the old contents (read-first). Contents are never reset.
//   Ports: clk; we/waddr/wdata write port; re/raddr read port; rdata
//   registered read data (holds while re is low).
// ---------------------------------------------------------------------------
module hmc_resp_ram #(
  parameter int LOG_DEPTH = 10,
  parameter int WIDTH     = 128
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [LOG_DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [LOG_DEPTH-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**LOG_DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; samples the array before this cycle's write lands.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/hmc_mem_responder.sv
// ---------------------------------------------------------------------------
// hmc_mem_responder
//   Memory-side responder for the Pico HMC user interface. Accepts RD, WR
//   and BW (byte-write) commands and write flits, and returns tagged read
//   flits from an internal 128-bit memory. Used as a loopback target for
//   AXI-to-HMC bridges when no physical HMC is present.
//
//   Ports:
//     clk, rst      sole clock, synchronous active-high reset
//     hmc (slave)   command / write-flit / read-flit channels and status
//     rd_cmd_count  RD commands accepted (wraps)
//     wr_cmd_count  WR + BW commands accepted (wraps)
//
//   Optional feature macro: HMC_RESP_OOR_CHECK_EN
//     defined   : flits whose full word index reaches DEPTH are out of range;
//                 reads return 0 with hmc_errstat = 7'h01, writes are dropped.
//     undefined : word index wraps modulo DEPTH, hmc_errstat tied to 0.
// ---------------------------------------------------------------------------
module hmc_mem_responder
  import hmc_mem_responder_pkg::*;
#(
  parameter int LOG_DEPTH = 10,
  parameter int TAG_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  hmc_mem_responder_if.slave  hmc,
  output logic [31:0]         rd_cmd_count,
  output logic [31:0]         wr_cmd_count
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR_DATA  = 2'd1;
  localparam logic [1:0] ST_BW_DATA  = 2'd2;
  localparam logic [1:0] ST_RD_BURST = 2'd3;

  logic [1:0]            state_r;
  logic [HMC_ADDR_W-1:0] addr_r;
  logic [3:0]            size_r;
  logic [3:0]            beat_cnt_r;
  logic [TAG_WIDTH-1:0]  tag_r;
  logic                  bw_phase_r;
  logic [63:0]           bw_data_r;
  logic [63:0]           bw_mask_r;
  logic                  rd_valid_r;
  logic [TAG_WIDTH-1:0]  rd_tag_r;
  logic                  rd_oor_r;
  logic [31:0]           rd_cnt_r;
  logic [31:0]           wr_cnt_r;

  logic                  cmd_ready_s;
  logic                  cmd_fire_s;
  logic                  wr_ready_s;
  logic                  wr_fire_s;
  logic                  rd_issue_s;
  logic                  last_s;
  logic [LOG_DEPTH-1:0]  word_s;
  logic                  oor_s;
  logic                  ram_we_s;
  logic                  ram_re_s;
  logic [LOG_DEPTH-1:0]  ram_waddr_s;
  logic [LOG_DEPTH-1:0]  ram_raddr_s;
  logic [HMC_DATA_W-1:0] ram_wdata_s;
  logic [HMC_DATA_W-1:0] ram_q_s;
  logic [HMC_DATA_W-1:0] bw_word_s;
  logic                  unused_s;

  // Handshakes and burst position.
  assign cmd_ready_s = (state_r == ST_IDLE) & ~rst;
  assign cmd_fire_s  = hmc.hmc_cmd_valid & cmd_ready_s;
  // BW takes exactly one flit, then a read-modify-write cycle with ready low.
  assign wr_ready_s  = ((state_r == ST_WR_DATA) |
                        ((state_r == ST_BW_DATA) & ~bw_phase_r)) & ~rst;
  assign wr_fire_s   = hmc.hmc_wr_data_valid & wr_ready_s;
  assign rd_issue_s  = (state_r == ST_RD_BURST) & hmc.hmc_rd_data_ready;
  // size 0 means 16 flits, which the 4-bit subtraction handles naturally.
  assign last_s      = (beat_cnt_r == (size_r - 4'd1));
  assign word_s      = addr_r[LOG_DEPTH+3:4] + LOG_DEPTH'(beat_cnt_r);

`ifdef HMC_RESP_OOR_CHECK_EN
  logic [30:0] full_idx_s;
  logic [6:0]  errstat_r;

  assign full_idx_s = {1'b0, addr_r[HMC_ADDR_W-1:4]} + 31'(beat_cnt_r);
  assign oor_s      = (full_idx_s >= 31'(2**LOG_DEPTH));

  // Error status accompanies each out-of-range read flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      errstat_r <= 7'h00;
    end else if (rd_issue_s && oor_s) begin
      errstat_r <= 7'h01;
    end else begin
      errstat_r <= 7'h00;
    end
  end

  assign hmc.hmc_errstat = errstat_r;
`else
  assign oor_s           = 1'b0;
  assign hmc.hmc_errstat = 7'h00;
`endif

  // Address bits not used for word selection (byte offset, upper bits).
  assign unused_s = ^{addr_r[2:0], addr_r[HMC_ADDR_W-1:LOG_DEPTH+4]};

  // Merge the latched BW flit into the 64-bit lane picked by addr[3].
  always_comb begin
    if (addr_r[3]) begin
      bw_word_s = {bw_merge(ram_q_s[127:64], bw_data_r, bw_mask_r), ram_q_s[63:0]};
    end else begin
      bw_word_s = {ram_q_s[127:64], bw_merge(ram_q_s[63:0], bw_data_r, bw_mask_r)};
    end
  end

  // RAM port steering: WR flits and the BW write-back share the write port;
  // read bursts and the BW old-word fetch share the read port.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    ram_waddr_s = word_s;
    ram_raddr_s = word_s;
    ram_wdata_s = hmc.hmc_wr_data;
    case (state_r)
      ST_WR_DATA: begin
        if (wr_fire_s && !oor_s) begin
          ram_we_s = 1'b1;
        end else begin
          ram_we_s = 1'b0;
        end
      end
      ST_BW_DATA: begin
        if (!bw_phase_r) begin
          ram_re_s = wr_fire_s;
        end else begin
          ram_we_s    = ~oor_s;
          ram_wdata_s = bw_word_s;
        end
      end
      ST_RD_BURST: begin
        ram_re_s = rd_issue_s;
      end
      default: begin
        ram_we_s = 1'b0;
      end
    endcase
  end

  hmc_resp_ram #(
    .LOG_DEPTH (LOG_DEPTH),
    .WIDTH     (HMC_DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .re    (ram_re_s),
    .raddr (ram_raddr_s),
    .rdata (ram_q_s)
  );

  // Read-flit pipeline: a flit leaves one cycle after its issue cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_tag_r   <= {TAG_WIDTH{1'b0}};
      rd_oor_r   <= 1'b0;
    end else begin
      rd_valid_r <= rd_issue_s;
      rd_tag_r   <= rd_issue_s ? tag_r : {TAG_WIDTH{1'b0}};
      rd_oor_r   <= rd_issue_s & oor_s;
    end
  end

  // Command FSM, burst counter and command counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      addr_r     <= {HMC_ADDR_W{1'b0}};
      size_r     <= 4'd0;
      beat_cnt_r <= 4'd0;
      tag_r      <= {TAG_WIDTH{1'b0}};
      bw_phase_r <= 1'b0;
      bw_data_r  <= 64'd0;
      bw_mask_r  <= 64'd0;
      rd_cnt_r   <= 32'd0;
      wr_cnt_r   <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_fire_s) begin
            addr_r     <= hmc.hmc_addr;
            size_r     <= hmc.hmc_size;
            tag_r      <= hmc.hmc_tag;
            beat_cnt_r <= 4'd0;
            bw_phase_r <= 1'b0;
            case (hmc.hmc_cmd)
              HMC_CMD_RD: begin
                state_r  <= ST_RD_BURST;
                rd_cnt_r <= rd_cnt_r + 32'd1;
              end
              HMC_CMD_WR: begin
                state_r  <= ST_WR_DATA;
                wr_cnt_r <= wr_cnt_r + 32'd1;
              end
              HMC_CMD_BW: begin
                state_r  <= ST_BW_DATA;
                wr_cnt_r <= wr_cnt_r + 32'd1;
              end
              default: begin
                // Unknown command codes are swallowed without effect.
                state_r <= ST_IDLE;
              end
            endcase
          end
        end
        ST_WR_DATA: begin
          if (wr_fire_s) begin
            beat_cnt_r <= beat_cnt_r + 4'd1;
            if (last_s) begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_BW_DATA: begin
          if (!bw_phase_r) begin
            if (wr_fire_s) begin
              bw_phase_r <= 1'b1;
              bw_data_r  <= hmc.hmc_wr_data[63:0];
              bw_mask_r  <= hmc.hmc_wr_data[127:64];
            end
          end else begin
            // Old word is now on the RAM output; write-back happens this cycle.
            bw_phase_r <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        ST_RD_BURST: begin
          if (rd_issue_s) begin
            beat_cnt_r <= beat_cnt_r + 4'd1;
            if (last_s) begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign hmc.hmc_cmd_ready     = cmd_ready_s;
  assign hmc.hmc_wr_data_ready = wr_ready_s;
  assign hmc.hmc_rd_data_valid = rd_valid_r;
  assign hmc.hmc_rd_data_tag   = rd_tag_r;
  // RAM output is only meaningful alongside valid; out-of-range flits read 0.
  assign hmc.hmc_rd_data       = (rd_valid_r && !rd_oor_r) ? ram_q_s : 128'd0;
  assign hmc.hmc_dinv          = 1'b0;
  assign rd_cmd_count          = rd_cnt_r;
  assign wr_cmd_count          = wr_cnt_r;

endmodule

// File: tb/tb_hmc_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_hmc_mem_responder
//   Directed self-checking bench for hmc_mem_responder. Inputs are driven
//   and outputs sampled on the falling clock edge; a monitor collects every
//   read flit into queues that the directed steps then compare against
//   hand-computed values.
// ---------------------------------------------------------------------------
module tb_hmc_mem_responder;
  import hmc_mem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_cmd_count;
  logic [31:0] wr_cmd_count;
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;

  logic [127:0] q_data[$];
  logic [5:0]   q_tag[$];
  logic [6:0]   q_err[$];
  int           q_cyc[$];

  localparam logic [127:0] BW_EXP = 128'hFFFFFFFF_FFFFFF00_FFFFFFFF_FFFFFFFF;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  hmc_mem_responder_if #(.TAG_WIDTH(6)) hmc_if ();

  hmc_mem_responder #(.LOG_DEPTH(10), .TAG_WIDTH(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .hmc          (hmc_if),
    .rd_cmd_count (rd_cmd_count),
    .wr_cmd_count (wr_cmd_count)
  );

  // Flit monitor
  always @(negedge clk) begin
    if (hmc_if.hmc_rd_data_valid === 1'b1) begin
      q_data.push_back(hmc_if.hmc_rd_data);
      q_tag.push_back(hmc_if.hmc_rd_data_tag);
      q_err.push_back(hmc_if.hmc_errstat);
      q_cyc.push_back(cyc);
    end
  end

  // Watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int i);
    logic [31:0] w;
    w = 32'h5A5A_0000 ^ 32'(i);
    return {w, ~w, w, 32'(i)};
  endfunction

  task automatic send_cmd(input logic [3:0] cmd, input logic [33:0] addr,
                          input logic [3:0] size, input logic [5:0] tag);
    int n;
    n = 0;
    hmc_if.hmc_cmd_valid = 1'b1;
    hmc_if.hmc_cmd       = cmd;
    hmc_if.hmc_addr      = addr;
    hmc_if.hmc_size      = size;
    hmc_if.hmc_tag       = tag;
    while (hmc_if.hmc_cmd_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) chk("cmd_ready_timeout", 128'(n), 128'd0);
    @(negedge clk);
    hmc_if.hmc_cmd_valid = 1'b0;
  endtask

  task automatic send_flit(input logic [127:0] data);
    int n;
    n = 0;
    hmc_if.hmc_wr_data_valid = 1'b1;
    hmc_if.hmc_wr_data       = data;
    while (hmc_if.hmc_wr_data_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) chk("wr_ready_timeout", 128'(n), 128'd0);
    @(negedge clk);
    hmc_if.hmc_wr_data_valid = 1'b0;
  endtask

  task automatic wait_flits(input string name, input int n);
    int b;
    b = 0;
    while (q_data.size() < n && b < 100) begin
      @(negedge clk);
      b++;
    end
    repeat (4) @(negedge clk);
    chk(name, 128'(q_data.size()), 128'(n));
  endtask

  task automatic clear_q();
    q_data.delete();
    q_tag.delete();
    q_err.delete();
    q_cyc.delete();
  endtask

  initial begin
    rst                      = 1'b1;
    hmc_if.hmc_cmd_valid     = 1'b0;
    hmc_if.hmc_cmd           = 4'd0;
    hmc_if.hmc_addr          = 34'd0;
    hmc_if.hmc_size          = 4'd0;
    hmc_if.hmc_tag           = 6'd0;
    hmc_if.hmc_wr_data       = 128'd0;
    hmc_if.hmc_wr_data_valid = 1'b0;
    hmc_if.hmc_rd_data_ready = 1'b1;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready",  128'(hmc_if.hmc_cmd_ready), 128'd0);
    rst = 1'b0;
    #1;
    chk("rst_rd_valid",   128'(hmc_if.hmc_rd_data_valid), 128'd0);
    chk("rst_rd_data",    hmc_if.hmc_rd_data, 128'd0);
    chk("rst_rd_tag",     128'(hmc_if.hmc_rd_data_tag), 128'd0);
    chk("rst_wr_ready",   128'(hmc_if.hmc_wr_data_ready), 128'd0);
    chk("rst_errstat",    128'(hmc_if.hmc_errstat), 128'd0);
    chk("rst_dinv",       128'(hmc_if.hmc_dinv), 128'd0);
    chk("rst_rd_count",   128'(rd_cmd_count), 128'd0);
    chk("rst_wr_count",   128'(wr_cmd_count), 128'd0);
    chk("idle_cmd_ready", 128'(hmc_if.hmc_cmd_ready), 128'd1);

    // ---- WR 0x40 size 2, then RD back with tag 5 ----
    send_cmd(HMC_CMD_WR, 34'h40, 4'd2, 6'd0);
    send_flit(128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004);
    send_flit(128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004);
    send_cmd(HMC_CMD_RD, 34'h40, 4'd2, 6'd5);
    wait_flits("rd2_count", 2);
    chk("rd2_data0", q_data[0], 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004);
    chk("rd2_data1", q_data[1], 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004);
    chk("rd2_tag0",  128'(q_tag[0]), 128'd5);
    chk("rd2_tag1",  128'(q_tag[1]), 128'd5);
    chk("rd2_err0",  128'(q_err[0]), 128'd0);
    chk("rd2_back2back", 128'(q_cyc[1] - q_cyc[0]), 128'd1);
    chk("cnt_rd_1",  128'(rd_cmd_count), 128'd1);
    chk("cnt_wr_1",  128'(wr_cmd_count), 128'd1);
    clear_q();

    // ---- byte-write into upper lane of word 4 ----
    send_cmd(HMC_CMD_WR, 34'h40, 4'd1, 6'd0);
    send_flit({128{1'b1}});
    send_cmd(HMC_CMD_BW, 34'h48, 4'd1, 6'd0);
    send_flit({56'hFF_FFFF_FFFF_FFFF, 8'h00, 64'h0});
    chk("bw_ready_drop", 128'(hmc_if.hmc_wr_data_ready), 128'd0);
    send_cmd(HMC_CMD_RD, 34'h40, 4'd1, 6'd9);
    wait_flits("bw_count", 1);
    chk("bw_data", q_data[0], BW_EXP);
    chk("bw_tag",  128'(q_tag[0]), 128'd9);
    clear_q();

    // ---- RD size 8 with a 4-cycle ready stall after 3 issues ----
    send_cmd(HMC_CMD_WR, 34'h100, 4'd8, 6'd0);
    for (int i = 0; i < 8; i++) send_flit(pat(i));
    send_cmd(HMC_CMD_RD, 34'h100, 4'd8, 6'd3);
    repeat (3) @(negedge clk);
    hmc_if.hmc_rd_data_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("stall_partial", 128'(q_data.size()), 128'd3);
    hmc_if.hmc_rd_data_ready = 1'b1;
    wait_flits("stall_count", 8);
    for (int i = 0; i < 8; i++) chk($sformatf("stall_data%0d", i), q_data[i], pat(i));
    clear_q();

    // ---- RD size 0 = 16 flits ----
    send_cmd(HMC_CMD_RD, 34'h0, 4'd0, 6'd7);
    wait_flits("rd16_count", 16);
    chk("rd16_word4", q_data[4], BW_EXP);
    chk("rd16_tag15", 128'(q_tag[15]), 128'd7);
    chk("rd16_span",  128'(q_cyc[15] - q_cyc[0]), 128'd15);
    clear_q();

`ifndef HMC_RESP_OOR_CHECK_EN
    // ---- WR at last word wraps into word 0 ----
    send_cmd(HMC_CMD_WR, 34'h3FF0, 4'd2, 6'd0);
    send_flit(128'hCCCC_CCCC_0000_1111_CCCC_CCCC_0000_2222);
    send_flit(128'hDDDD_DDDD_0000_3333_DDDD_DDDD_0000_4444);
    send_cmd(HMC_CMD_RD, 34'h0, 4'd1, 6'd2);
    wait_flits("wrap_count0", 1);
    chk("wrap_word0", q_data[0], 128'hDDDD_DDDD_0000_3333_DDDD_DDDD_0000_4444);
    clear_q();
    send_cmd(HMC_CMD_RD, 34'h3FF0, 4'd2, 6'd2);
    wait_flits("wrap_count1", 2);
    chk("wrap_rd_last",  q_data[0], 128'hCCCC_CCCC_0000_1111_CCCC_CCCC_0000_2222);
    chk("wrap_rd_first", q_data[1], 128'hDDDD_DDDD_0000_3333_DDDD_DDDD_0000_4444);
    clear_q();
    chk("cnt_rd_6", 128'(rd_cmd_count), 128'd6);
    chk("cnt_wr_5", 128'(wr_cmd_count), 128'd5);
`else
    // ---- out-of-range read ----
    send_cmd(HMC_CMD_RD, 34'h4000, 4'd1, 6'd4);
    wait_flits("oor_count", 1);
    chk("oor_data", q_data[0], 128'd0);
    chk("oor_err",  128'(q_err[0]), 128'h01);
    clear_q();
    chk("cnt_rd_5", 128'(rd_cmd_count), 128'd5);
    chk("cnt_wr_4", 128'(wr_cmd_count), 128'd4);
`endif

    // ---- reset in the middle of a read burst ----
    send_cmd(HMC_CMD_RD, 34'h100, 4'd8, 6'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid",    128'(hmc_if.hmc_rd_data_valid), 128'd0);
    chk("mid_rst_rd_count", 128'(rd_cmd_count), 128'd0);
    chk("mid_rst_wr_count", 128'(wr_cmd_count), 128'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 128'(hmc_if.hmc_cmd_ready), 128'd1);
    clear_q();
    send_cmd(HMC_CMD_RD, 34'h40, 4'd1, 6'd6);
    wait_flits("post_rst_count", 1);
    chk("post_rst_data",  q_data[0], BW_EXP);
    chk("post_rst_tag",   128'(q_tag[0]), 128'd6);
    chk("post_rst_rdcnt", 128'(rd_cmd_count), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
